g11620_cfg_ctrl: RTL and testbench
==================================

# g11620_cfg_ctrl

Configuration register file and run sequencer for the G11620 sensor controller. It owns the 16×32 configuration register file and arbitrates its single port between a host bus (command decoder) and the sensor controller's fixed-latency read port. It generates the sensor's start and soft-reset pulses, tracks busy/done, supports continuous re-triggering, and enforces a completion timeout.

## Interface
- `REG_NUM`, 16: number of 32-bit configuration registers.
- `TIMEOUT`, 32'd50_000_000: clk cycles allowed between start and done before auto-abort.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `host_req`  in  1: host access request, held until `host_ack`.
- `host_wr`  in  1: 1 = write, 0 = read; stable while `host_req` is high.
- `host_addr`  in  4: register index.
- `host_wdata`  in  32: write data.
- `host_ack`  out  1: one-cycle completion pulse.
- `host_rdata`  out  32: read data, valid in the `host_ack` cycle.
- `host_err`  out  1: qualifies `host_ack`; the access was rejected.
- `sen_rd`  in  1: sensor read strobe.
- `sen_addr`  in  8: sensor read address.
- `sen_rdata`  out  32: sensor read data.
- `sen_start`  out  1: start pulse to the sensor controller.
- `sen_soft_reset`  out  1: abort pulse to the sensor controller.
- `sen_done`  in  1: sensor done level (multi-cycle).
- `busy`  out  1: acquisition in progress.

## Operation
- Register map:
  - 0 CTRL: bit0 start (self-clearing), bit1 soft reset (self-clearing), bit2 continuous (sticky). Reads return `{29'b0, cont, 2'b0}`.
  - 1 INTEG, 2 CAP, 3 GAP (restart gap in cycles), 4–6 general purpose.
  - 7 STATUS, read-only: `{frame_cnt[15:0], 13'b0, timeout_flag, cont, busy}`.
  - 8–15 general purpose.
- Sensor port has absolute priority. When `sen_rd` is high at edge N, `sen_rdata` takes `reg[sen_addr]` at N+1 and holds until the next `sen_rd`. Addresses ≥ `REG_NUM` return 0.
- Host FSM has two states, H_IDLE and H_ACK.
  - In H_IDLE, `host_req` high and `sen_rd` low at edge N: perform the access and go to H_ACK. `host_ack` is high during cycle N+1.
  - `host_req` is ignored in the H_ACK cycle.
  - If `sen_rd` is high, the host waits with no limit.
- Host accesses rejected with `host_err`=1 and the register left unchanged:
  - any write to addr 7;
  - writes to addr 1, 2 or 3 while `busy`=1.
- Run FSM states are R_IDLE, R_RUN, R_GAP.
  - R_IDLE + CTRL write with bit0=1 and bit1=0: pulse `sen_start` for 1 cycle, go to R_RUN, `busy`=1.
  - R_RUN + `sen_done` rising edge: increment `frame_cnt`. If cont=1, load the gap counter with GAP and go to R_GAP. Otherwise go to R_IDLE and set `busy`=0.
  - R_GAP: count down. When the counter is 0, pulse `sen_start` and return to R_RUN. GAP=0 gives a restart on the cycle after the done edge.
  - CTRL write with bit1=1, from any state: pulse `sen_soft_reset`, go to R_IDLE, `busy`=0. A start bit in the same write is dropped.
  - R_RUN with the timeout counter reaching TIMEOUT−1: pulse `sen_soft_reset`, set `timeout_flag`, go to R_IDLE.
  - `timeout_flag` clears on a host read of STATUS.
  - A start write while `busy`=1 is ignored, with no error.
  - `sen_done` seen outside R_RUN is ignored.
  - Clearing cont during R_GAP ends the run at the gap's end, with no restart.
- `frame_cnt` wraps from 0xFFFF to 0. It clears only on reset.

## Timing
- Reset values:
  - `host_ack`, `host_err`, `sen_start`, `sen_soft_reset`, `busy` = 0.
  - `host_rdata`, `sen_rdata`, all registers, `frame_cnt`, `timeout_flag` = 0.
  - Run FSM in R_IDLE, host FSM in H_IDLE.
- Reset during a run drops `busy` with no `sen_soft_reset` pulse. The sensor shares `rst_n`.
- Host latency: 1 cycle without contention, plus 1 cycle per contending `sen_rd`.
- `sen_start` is asserted in the cycle after the CTRL write's `host_ack` edge, i.e. N+1 relative to acceptance at N. `busy` rises in the same cycle.
- The done edge is detected from a 1-cycle registered copy of `sen_done`. `busy` falls 1 cycle after the edge is sampled.

## Structure
- Shared package `g11620_pkg` holds:
  - register address constants (CTRL=0, INTEG=1, CAP=2, GAP=3, STATUS=7);
  - CTRL bit positions;
  - run and host FSM encodings.
- The address constants there replace the standalone address header for the sensor controller.
- One sub-module, `g11620_run_seq`, holds the run FSM, gap counter, timeout counter and `frame_cnt`. The top level holds the register file and the host/sensor arbitration.

## Test plan
- Reset, then host write INTEG=100 and read it back. Response: `host_ack` at N+1, `host_rdata`=100, `host_err`=0.
- `sen_rd` at addr 1 in the same cycle as a host write to addr 4. Response: `sen_rdata`=100 at N+1, `host_ack` delayed to N+2.
- Write CTRL=1. Response: one `sen_start` pulse and `busy`=1. Then a write INTEG=5 returns `host_err`=1 and INTEG stays 100. Drive `sen_done` high for 33 cycles. Response: `busy`=0, and STATUS reads 0x0001_0000.
- cont=1, GAP=10, start, then done. Response: next `sen_start` exactly 11 cycles after the sampled done edge. Then write CTRL=0x2. Response: `sen_soft_reset` pulse, `busy`=0, no further start.
- TIMEOUT=20 and start with no done. Response: `sen_soft_reset` 20 cycles after start, STATUS bit2=1, and bit2=0 on the next STATUS read.
- Write CTRL=0x3 while idle. Response: only `sen_soft_reset`, with no `sen_start`. A write to addr 7 returns `host_err`=1.

Source files
------------

// File: rtl/g11620_pkg.sv
// Shared definitions for the G11620 configuration controller: register map,
// CTRL bit positions and FSM encodings.
package g11620_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_INTEG  = 4'd1;
  localparam logic [3:0] ADDR_CAP    = 4'd2;
  localparam logic [3:0] ADDR_GAP    = 4'd3;
  localparam logic [3:0] ADDR_STATUS = 4'd7;

  localparam int CTRL_START = 0;
  localparam int CTRL_SRST  = 1;
  localparam int CTRL_CONT  = 2;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_RUN  = 2'd1,
    R_GAP  = 2'd2
  } run_state_t;

  typedef enum logic {
    H_IDLE = 1'b0,
    H_ACK  = 1'b1
  } host_state_t;

  // Acquisition parameters that must not change under a running sensor.
  function automatic logic is_run_param(input logic [3:0] addr);
    return (addr == ADDR_INTEG) || (addr == ADDR_CAP) || (addr == ADDR_GAP);
  endfunction

  function automatic logic [31:0] pack_status(input logic [15:0] frame_cnt,
                                              input logic        timeout_flag,
                                              input logic        cont,
                                              input logic        busy);
    return {frame_cnt, 13'b0, timeout_flag, cont, busy};
  endfunction

endpackage

// File: rtl/g11620_run_seq.sv
// Run sequencer: start/soft-reset pulse generation, continuous restart gap,
// completion timeout and frame counting.
module g11620_run_seq
  import g11620_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_req,
  input  logic        srst_req,
  input  logic        cont,
  input  logic [31:0] gap,
  input  logic        sen_done,
  input  logic        status_clr,
  output logic        sen_start,
  output logic        sen_soft_reset,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        timeout_flag
);

  run_state_t  state;
  run_state_t  state_next;
  logic [31:0] gap_cnt;
  logic [31:0] gap_next;
  logic [31:0] tmo_cnt;
  logic [31:0] tmo_next;
  logic        done_q;
  logic        done_rise;
  logic        start_next;
  logic        srst_next;
  logic        frame_inc;
  logic        tmo_set;

  assign done_rise = sen_done && !done_q;
  assign busy      = (state != R_IDLE);

  // A soft-reset write overrides everything; a done edge wins over a timeout
  // landing in the same cycle.
  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    start_next = 1'b0;
    srst_next  = 1'b0;
    frame_inc  = 1'b0;
    tmo_set    = 1'b0;
    if (srst_req) begin
      state_next = R_IDLE;
      srst_next  = 1'b1;
    end else begin
      case (state)
        R_IDLE: begin
          if (start_req) begin
            state_next = R_RUN;
            start_next = 1'b1;
          end
        end
        R_RUN: begin
          if (done_rise) begin
            frame_inc = 1'b1;
            if (cont) begin
              gap_next   = gap;
              state_next = R_GAP;
            end else begin
              state_next = R_IDLE;
            end
          end else if (tmo_cnt == TIMEOUT - 32'd1) begin
            srst_next  = 1'b1;
            tmo_set    = 1'b1;
            state_next = R_IDLE;
          end
        end
        R_GAP: begin
          if (gap_cnt == 32'd0) begin
            if (cont) begin
              start_next = 1'b1;
              state_next = R_RUN;
            end else begin
              state_next = R_IDLE;
            end
          end else begin
            gap_next = gap_cnt - 32'd1;
          end
        end
        default: state_next = R_IDLE;
      endcase
    end
    tmo_next = ((state == R_RUN) && (state_next == R_RUN)) ? tmo_cnt + 32'd1 : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= R_IDLE;
      gap_cnt        <= '0;
      tmo_cnt        <= '0;
      done_q         <= 1'b0;
      sen_start      <= 1'b0;
      sen_soft_reset <= 1'b0;
      frame_cnt      <= '0;
      timeout_flag   <= 1'b0;
    end else begin
      state          <= state_next;
      gap_cnt        <= gap_next;
      tmo_cnt        <= tmo_next;
      done_q         <= sen_done;
      sen_start      <= start_next;
      sen_soft_reset <= srst_next;
      if (frame_inc) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (tmo_set) begin
        timeout_flag <= 1'b1;
      end else if (status_clr) begin
        timeout_flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/g11620_cfg_ctrl.sv
// Configuration register file with host/sensor port arbitration; the sensor
// read port always wins and the host waits behind it.
module g11620_cfg_ctrl
  import g11620_pkg::*;
#(
  parameter int unsigned REG_NUM = 16,
  parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [3:0]  host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  output logic [31:0] host_rdata,
  output logic        host_err,
  input  logic        sen_rd,
  input  logic [7:0]  sen_addr,
  output logic [31:0] sen_rdata,
  output logic        sen_start,
  output logic        sen_soft_reset,
  input  logic        sen_done,
  output logic        busy
);

  logic [31:0] regs [REG_NUM];
  host_state_t host_state;
  host_state_t host_next;
  logic        access;
  logic        reject;
  logic        do_write;
  logic        ctrl_wr;
  logic        start_req;
  logic        srst_req;
  logic        status_clr;
  logic        cont;
  logic        host_in_range;
  logic        sen_in_range;
  logic [15:0] frame_cnt;
  logic        timeout_flag;
  logic [31:0] status_word;
  logic [31:0] host_word;
  logic [31:0] sen_word;

  assign cont          = regs[ADDR_CTRL][CTRL_CONT];
  assign status_word   = pack_status(frame_cnt, timeout_flag, cont, busy);
  assign host_in_range = ({28'b0, host_addr} < REG_NUM);
  assign sen_in_range  = ({24'b0, sen_addr} < REG_NUM);

  always_comb begin
    host_next = host_state;
    access    = 1'b0;
    host_ack  = 1'b0;
    case (host_state)
      H_IDLE: begin
        if (host_req && !sen_rd) begin
          access    = 1'b1;
          host_next = H_ACK;
        end
      end
      H_ACK: begin
        host_ack  = 1'b1;
        host_next = H_IDLE;
      end
    endcase
  end

  // Only the cont bit of CTRL is stored; start and soft reset act as pulses.
  always_comb begin
    reject     = host_wr && ((host_addr == ADDR_STATUS) || (busy && is_run_param(host_addr)));
    do_write   = access && host_wr && !reject && host_in_range;
    ctrl_wr    = do_write && (host_addr == ADDR_CTRL);
    start_req  = ctrl_wr && host_wdata[CTRL_START] && !host_wdata[CTRL_SRST];
    srst_req   = ctrl_wr && host_wdata[CTRL_SRST];
    status_clr = access && !host_wr && (host_addr == ADDR_STATUS);
  end

  always_comb begin
    host_word = '0;
    if (host_in_range) begin
      host_word = (host_addr == ADDR_STATUS) ? status_word : regs[host_addr];
    end
    sen_word = '0;
    if (sen_in_range) begin
      sen_word = (sen_addr[3:0] == ADDR_STATUS) ? status_word : regs[sen_addr[3:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      host_state <= H_IDLE;
      host_rdata <= '0;
      host_err   <= 1'b0;
      sen_rdata  <= '0;
      regs       <= '{default: '0};
    end else begin
      host_state <= host_next;
      host_err   <= access && reject;
      if (access && !host_wr) begin
        host_rdata <= host_word;
      end
      if (sen_rd) begin
        sen_rdata <= sen_word;
      end
      if (do_write) begin
        if (host_addr == ADDR_CTRL) begin
          regs[host_addr] <= {29'b0, host_wdata[CTRL_CONT], 2'b0};
        end else begin
          regs[host_addr] <= host_wdata;
        end
      end
    end
  end

  g11620_run_seq #(
    .TIMEOUT(TIMEOUT)
  ) u_run_seq (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_req     (start_req),
    .srst_req      (srst_req),
    .cont          (cont),
    .gap           (regs[ADDR_GAP]),
    .sen_done      (sen_done),
    .status_clr    (status_clr),
    .sen_start     (sen_start),
    .sen_soft_reset(sen_soft_reset),
    .busy          (busy),
    .frame_cnt     (frame_cnt),
    .timeout_flag  (timeout_flag)
  );

endmodule

// File: tb/tb_g11620_cfg_ctrl.sv
// Self-checking bench for g11620_cfg_ctrl against a register-map and
// cycle-count model derived from the controller's documented behaviour.
module tb_g11620_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_req = 1'b0;
  logic        host_wr = 1'b0;
  logic [3:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        host_err;
  logic        sen_rd = 1'b0;
  logic [7:0]  sen_addr = '0;
  logic [31:0] sen_rdata;
  logic        sen_start;
  logic        sen_soft_reset;
  logic        sen_done = 1'b0;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_count = 0;
  int srst_count = 0;
  int last_start_cyc = -1;
  int last_srst_cyc = -1;
  int ack_cyc = 0;

  logic [31:0] m_regs [16];
  logic        m_cont = 1'b0;
  logic        m_tflag = 1'b0;
  logic [15:0] m_frames = '0;

  logic [31:0] rd;
  logic        er;
  int          lt;

  g11620_cfg_ctrl #(
    .REG_NUM(16),
    .TIMEOUT(32'd20)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host_req      (host_req),
    .host_wr       (host_wr),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_ack      (host_ack),
    .host_rdata    (host_rdata),
    .host_err      (host_err),
    .sen_rd        (sen_rd),
    .sen_addr      (sen_addr),
    .sen_rdata     (sen_rdata),
    .sen_start     (sen_start),
    .sen_soft_reset(sen_soft_reset),
    .sen_done      (sen_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sen_start) begin
      start_count    <= start_count + 1;
      last_start_cyc <= cyc;
    end
    if (sen_soft_reset) begin
      srst_count    <= srst_count + 1;
      last_srst_cyc <= cyc;
    end
  end

  function automatic logic [31:0] model_read(input int unsigned a, input logic bsy);
    if (a >= 16) return 32'h0;
    if (a == 0) return {29'b0, m_cont, 2'b0};
    if (a == 7) return {m_frames, 13'b0, m_tflag, m_cont, bsy};
    return m_regs[a];
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic host_access(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                             input int contend, input logic [7:0] saddr,
                             output logic [31:0] rdata, output logic err, output int lat);
    logic got;
    got = 1'b0;
    rdata = '0;
    err = 1'b0;
    lat = 0;
    host_req = 1'b1;
    host_wr = wr;
    host_addr = addr;
    host_wdata = wdata;
    for (int i = 0; i < 50 && !got; i++) begin
      sen_rd = (i < contend);
      sen_addr = saddr;
      step(1);
      lat++;
      if (host_ack) begin
        got = 1'b1;
        rdata = host_rdata;
        err = host_err;
        ack_cyc = cyc;
      end
    end
    sen_rd = 1'b0;
    host_req = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("[TB] FAIL host_ack_timeout: addr=%0d no host_ack within 50 cycles", addr);
    end
    step(1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(3);
    checks++; if ({host_ack, host_err, sen_start, sen_soft_reset, busy} !== 5'b0) begin errors++;
      $display("[TB] FAIL reset_ctrl_outs: got %b expected 00000", {host_ack, host_err, sen_start, sen_soft_reset, busy}); end
    checks++; if (host_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_host_rdata: got %h expected 0", host_rdata); end
    checks++; if (sen_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_sen_rdata: got %h expected 0", sen_rdata); end
    rst_n = 1'b1;
    m_regs = '{default: '0};
    m_cont = 1'b0; m_tflag = 1'b0; m_frames = '0;
    step(1);
    host_access(1'b0, 4'd7, 32'h0, 0, 8'h0, rd, er, lt);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_status: got %h expected 0", rd); end
    host_access(1'b0, 4'd9, 32'h0, 0, 8'h0, rd, er, lt);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_reg9: got %h expected 0", rd); end
  endtask

  task automatic test_basic_rw;
    host_access(1'b1, 4'd1, 32'd100, 0, 8'h0, rd, er, lt);
    m_regs[1] = 32'd100;
    checks++; if (lt !== 1) begin errors++; $display("[TB] FAIL write_latency: got %0d expected 1", lt); end
    checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL write_err: got %b expected 0", er); end
    host_access(1'b0, 4'd1, 32'h0, 0, 8'h0, rd, er, lt);
    checks++; if (rd !== 32'd100) begin errors++; $display("[TB] FAIL integ_readback: got %0d expected 100", rd); end
    checks++; if (lt !== 1 || er !== 1'b0) begin errors++; $display("[TB] FAIL read_ack: lat=%0d err=%b expected 1/0", lt, er); end
  endtask

  task automatic test_contention;
    int k;
    int a;
    host_access(1'b1, 4'd4, 32'hCAFE_0004, 1, 8'd1, rd, er, lt);
    m_regs[4] = 32'hCAFE_0004;
    checks++; if (lt !== 2) begin errors++; $display("[TB] FAIL contention_latency: got %0d expected 2", lt); end
    checks++; if (sen_rdata !== 32'd100) begin errors++; $display("[TB] FAIL contention_sen_rdata: got %h expected %h", sen_rdata, 32'd100); end
    host_access(1'b0, 4'd4, 32'h0, 0, 8'h0, rd, er, lt);
    checks++; if (rd !== 32'hCAFE_0004) begin errors++; $display("[TB] FAIL contention_write: got %h expected cafe0004", rd); end
    for (int i = 0; i < 4; i++) begin
      k = $urandom_range(0, 3);
      a = $urandom_range(1, 6);
      host_access(1'b0, 4'(a), 32'h0, k, 8'd4, rd, er, lt);
      checks++; if (lt !== k + 1) begin errors++; $display("[TB] FAIL contention_wait: got %0d expected %0d", lt, k + 1); end
      checks++; if (rd !== model_read(a, 1'b0)) begin errors++; $display("[TB] FAIL contention_read: got %h expected %h", rd, model_read(a, 1'b0)); end
    end
  endtask

  task automatic test_start_done;
    int s0;
    s0 = start_count;
    host_access(1'b1, 4'd0, 32'h1, 0, 8'h0, rd, er, lt);
    m_cont = 1'b0;
    checks++; if (start_count !== s0 + 1) begin errors++; $display("[TB] FAIL start_pulse_count: got %0d expected %0d", start_count, s0 + 1); end
    checks++; if (last_start_cyc !== ack_cyc) begin errors++; $display("[TB] FAIL start_timing: got %0d expected %0d", last_start_cyc, ack_cyc); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL start_busy: got %b expected 1", busy); end
    host_access(1'b1, 4'd1, 32'd5, 0, 8'h0, rd, er, lt);
    checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL busy_write_err: got %b expected 1", er); end
    host_access(1'b0, 4'd1, 32'h0, 0, 8'h0, rd, er, lt);
    checks++; if (rd !== 32'd100) begin errors++; $display("[TB] FAIL busy_write_kept: got %0d expected 100", rd); end
    sen_done = 1'b1;
    step(33);
    sen_done = 1'b0;
    m_frames = m_frames + 16'd1;
    step(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL done_busy: got %b expected 0", busy); end
    checks++; if (start_count !== s0 + 1) begin errors++; $display("[TB] FAIL done_no_restart: got %0d expected %0d", start_count, s0 + 1); end
    host_access(1'b0, 4'd7, 32'h0, 0, 8'h0, rd, er, lt);
    checks++; if (rd !== 32'h0001_0000) begin errors++; $display("[TB] FAIL done_status: got %h expected 00010000", rd); end
  endtask

  task automatic test_random_regs;
    int gp [14] = '{1, 2, 3, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14, 15};
    int a;
    logic [31:0] d;
    for (int i = 0; i < 16; i++) begin
      a = gp[$urandom_range(0, 13)];
      d = $urandom;
      host_access(1'b1, 4'(a), d, 0, 8'h0, rd, er, lt);
      m_regs[a] = d;
      checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL rand_write_err: addr=%0d got %b expected 0", a, er); end
      a = gp[$urandom_range(0, 13)];
      host_access(1'b0, 4'(a), 32'h0, 0, 8'h0, rd, er, lt);
      checks++; if (rd !== model_read(a, 1'b0)) begin errors++; $display("[TB] FAIL rand_read: addr=%0d got %h expected %h", a, rd, model_read(a, 1'b0)); end
    end
  endtask

  task automatic test_sensor_port;
    int a;
    logic [31:0] exp;
    for (int i = 0; i < 16; i++) begin
      a = (i == 15) ? 255 : $urandom_range(0, 20);
      sen_addr = 8'(a);
      sen_rd = 1'b1;
      step(1);
      sen_rd = 1'b0;
      exp = model_read(a, 1'b0);
      checks++; if (sen_rdata !== exp) begin errors++; $display("[TB] FAIL sen_read: addr=%0d got %h expected %h", a, sen_rdata, exp); end
      sen_addr = 8'($urandom);
      step(2);
      checks++; if (sen_rdata !== exp) begin errors++; $display("[TB] FAIL sen_hold: addr=%0d got %h expected %h", a, sen_rdata, exp); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d1;
    logic [31:0] d2;
    int n;
    d1 = $urandom;
    d2 = $urandom;
    host_req = 1'b1; host_wr = 1'b1; host_addr = 4'd5; host_wdata = d1;
    n = 0;
    for (int i = 0; i < 10 && !host_ack; i++) begin step(1); n++; end
    checks++; if (n !== 1) begin errors++; $display("[TB] FAIL b2b_first_latency: got %0d expected 1", n); end
    host_addr = 4'd6; host_wdata = d2;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(1); n++;
      if (host_ack) break;
    end
    host_req = 1'b0;
    checks++; if (n !== 2) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d expected 2", n); end
    step(1);
    m_regs[5] = d1; m_regs[6] = d2;
    host_access(1'b0, 4'd5, 32'h0, 0, 8'h0, rd, er, lt);
    checks++; if (rd !== d1) begin errors++; $display("[TB] FAIL b2b_reg5: got %h expected %h", rd, d1); end
    host_access(1'b0, 4'd6, 32'h0, 0, 8'h0, rd, er, lt);
    checks++; if (rd !== d2) begin errors++; $display("[TB] FAIL b2b_reg6: got %h expected %h", rd, d2); end
  endtask

  task automatic test_continuous_gap;
    int gaps [3];
    int g;
    int s0;
    int ss;
    int e;
    gaps[0] = 10; gaps[1] = $urandom_range(1, 12); gaps[2] = 0;
    for (int k = 0; k < 3; k++) begin
      g = gaps[k];
      host_access(1'b1, 4'd3, 32'(g), 0, 8'h0, rd, er, lt);
      m_regs[3] = 32'(g);
      s0 = start_count;
      host_access(1'b1, 4'd0, 32'h5, 0, 8'h0, rd, er, lt);
      m_cont = 1'b1;
      checks++; if (start_count !== s0 + 1) begin errors++; $display("[TB] FAIL cont_first_start: got %0d expected %0d", start_count, s0 + 1); end
      step(2);
      sen_done = 1'b1;
      e = cyc + 1;
      step(1);
      sen_done = 1'b0;
      m_frames = m_frames + 16'd1;
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL gap_busy: got %b expected 1", busy); end
      for (int i = 0; i < 40 && start_count == s0 + 1; i++) step(1);
      checks++; if (start_count !== s0 + 2 || last_start_cyc !== e + g + 1) begin errors++;
        $display("[TB] FAIL gap_restart: gap=%0d starts=%0d at cycle %0d expected %0d at cycle %0d", g, start_count - s0, last_start_cyc, 2, e + g + 1); end
      ss = srst_count;
      host_access(1'b1, 4'd0, 32'h2, 0, 8'h0, rd, er, lt);
      m_cont = 1'b0;
      checks++; if (srst_count !== ss + 1) begin errors++; $display("[TB] FAIL cont_srst_pulse: got %0d expected %0d", srst_count, ss + 1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cont_srst_busy: got %b expected 0", busy); end
      step(15);
      checks++; if (start_count !== s0 + 2) begin errors++; $display("[TB] FAIL cont_no_restart: got %0d expected %0d", start_count, s0 + 2); end
    end
  endtask

  task automatic test_cont_clear_in_gap;
    int s0;
    int ss;
    int e;
    host_access(1'b1, 4'd3, 32'd10, 0, 8'h0, rd, er, lt);
    m_regs[3] = 32'd10;
    s0 = start_count;
    ss = srst_count;
    host_access(1'b1, 4'd0, 32'h5, 0, 8'h0, rd, er, lt);
    m_cont = 1'b1;
    step(2);
    sen_done = 1'b1;
    e = cyc + 1;
    step(1);
    sen_done = 1'b0;
    m_frames = m_frames + 16'd1;
    host_access(1'b1, 4'd0, 32'h0, 0, 8'h0, rd, er, lt);
    m_cont = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL clear_gap_busy: got %b expected 1", busy); end
    for (int i = 0; i < 40 && cyc < e + 12; i++) step(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL clear_gap_end_busy: got %b expected 0", busy); end
    checks++; if (start_count !== s0 + 1 || srst_count !== ss) begin errors++;
      $display("[TB] FAIL clear_gap_pulses: starts=%0d srsts=%0d expected 1 and 0", start_count - s0, srst_count - ss); end
  endtask

  task automatic test_timeout;
    int s0;
    int ss;
    int st;
    s0 = start_count;
    ss = srst_count;
    host_access(1'b1, 4'd0, 32'h1, 0, 8'h0, rd, er, lt);
    m_cont = 1'b0;
    st = ack_cyc;
    for (int i = 0; i < 60 && srst_count == ss; i++) step(1);
    checks++; if (srst_count !== ss + 1 || last_srst_cyc !== st + 20) begin errors++;
      $display("[TB] FAIL timeout_srst: count=%0d at cycle %0d expected 1 at cycle %0d", srst_count - ss, last_srst_cyc, st + 20); end
    checks++; if (busy !== 1'b0 || start_count !== s0 + 1) begin errors++;
      $display("[TB] FAIL timeout_idle: busy=%b starts=%0d expected 0 and 1", busy, start_count - s0); end
    m_tflag = 1'b1;
    host_access(1'b0, 4'd7, 32'h0, 0, 8'h0, rd, er, lt);
    checks++; if (rd !== model_read(7, 1'b0) || rd[2] !== 1'b1) begin errors++;
      $display("[TB] FAIL timeout_status_set: got %h expected %h", rd, model_read(7, 1'b0)); end
    m_tflag = 1'b0;
    host_access(1'b0, 4'd7, 32'h0, 0, 8'h0, rd, er, lt);
    checks++; if (rd !== model_read(7, 1'b0)) begin errors++;
      $display("[TB] FAIL timeout_status_clear: got %h expected %h", rd, model_read(7, 1'b0)); end
  endtask

  task automatic test_srst_priority;
    int s0;
    int ss;
    s0 = start_count;
    ss = srst_count;
    host_access(1'b1, 4'd0, 32'h3, 0, 8'h0, rd, er, lt);
    m_cont = 1'b0;
    step(1);
    checks++; if (srst_count !== ss + 1 || start_count !== s0) begin errors++;
      $display("[TB] FAIL srst_start_combo: srsts=%0d starts=%0d expected 1 and 0", srst_count - ss, start_count - s0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL srst_combo_busy: got %b expected 0", busy); end
    host_access(1'b1, 4'd7, $urandom, 0, 8'h0, rd, er, lt);
    checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL status_write_err: got %b expected 1", er); end
    host_access(1'b0, 4'd7, 32'h0, 0, 8'h0, rd, er, lt);
    checks++; if (rd !== model_read(7, 1'b0)) begin errors++; $display("[TB] FAIL status_unchanged: got %h expected %h", rd, model_read(7, 1'b0)); end
    host_access(1'b1, 4'd1, 32'd7, 0, 8'h0, rd, er, lt);
    m_regs[1] = 32'd7;
    checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL idle_integ_write: got %b expected 0", er); end
  endtask

  task automatic test_reset_during_run;
    int ss;
    host_access(1'b1, 4'd0, 32'h1, 0, 8'h0, rd, er, lt);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_run_busy: got %b expected 1", busy); end
    ss = srst_count;
    rst_n = 1'b0;
    step(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_run_drop: got %b expected 0", busy); end
    step(2);
    rst_n = 1'b1;
    m_regs = '{default: '0};
    m_cont = 1'b0; m_tflag = 1'b0; m_frames = '0;
    step(1);
    checks++; if (srst_count !== ss) begin errors++; $display("[TB] FAIL rst_run_no_srst: got %0d expected 0", srst_count - ss); end
    host_access(1'b0, 4'd1, 32'h0, 0, 8'h0, rd, er, lt);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rst_run_integ: got %h expected 0", rd); end
    host_access(1'b0, 4'd7, 32'h0, 0, 8'h0, rd, er, lt);
    checks++; if (rd !== model_read(7, 1'b0)) begin errors++; $display("[TB] FAIL rst_run_status: got %h expected %h", rd, model_read(7, 1'b0)); end
  endtask

  initial begin
    test_reset;
    test_basic_rw;
    test_contention;
    test_start_done;
    test_random_regs;
    test_sensor_port;
    test_back_to_back;
    test_continuous_gap;
    test_cont_clear_in_gap;
    test_timeout;
    test_srst_priority;
    test_reset_during_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
